// File: rtl/alu_control_md.sv
// alu_control_md: ALU operation decode plus iterative mult/div unit with HI/LO registers
module alu_control_md #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       ALUop,
  input  logic [5:0]       Func,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [2:0]       ALUoper,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*WIDTH-1:0] p_q, p_d, prod;
  logic [WIDTH-1:0] m_q, m_d, a_q, a_d, hi_q, hi_d, lo_q, lo_d;
  logic div_q, div_d, neg_q, neg_d, rneg_q, rneg_d, busy_q, busy_d, done_q, done_d;
  logic accept, last, sgn;
  logic [WIDTH-1:0] abs_a, abs_b, quo, rem;
  logic [WIDTH:0] sum, trial;
  assign sgn    = ~Func[0];
  assign abs_a  = (sgn && a[WIDTH-1]) ? -a : a;
  assign abs_b  = (sgn && b[WIDTH-1]) ? -b : b;
  assign accept = start && ALUop == 2'b10 && Func[5:2] == 4'b0110 && state_q == IDLE;
  assign last   = cnt_q == CNT_W'(WIDTH - 1);
  assign busy   = busy_q;
  assign done   = done_q;
  assign hi     = hi_q;
  assign lo     = lo_q;
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = accept ? (Func[1] ? DIV : MUL) : IDLE;
      MUL, DIV: state_d = last ? FIX : state_q;
      FIX:      state_d = DONE;
      default:  state_d = IDLE;
    endcase
  end
  always_comb begin
    ALUoper = 3'b010;
    if (ALUop == 2'b01) ALUoper = 3'b110;
    else if (ALUop == 2'b10)
      case (Func)
        6'b100010, 6'b100011: ALUoper = 3'b110;
        6'b100100:            ALUoper = 3'b000;
        6'b100101:            ALUoper = 3'b001;
        6'b100111:            ALUoper = 3'b100;
        6'b101010, 6'b101011: ALUoper = 3'b111;
        default:              ALUoper = 3'b010;
      endcase
  end
  // p_q holds {acc, multiplier} for MUL and {remainder, dividend/quotient} for DIV
  always_comb begin
    sum    = {1'b0, p_q[2*WIDTH-1:WIDTH]} + (p_q[0] ? {1'b0, m_q} : '0);
    trial  = {p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1]};
    prod   = neg_q ? -p_q : p_q;
    quo    = neg_q ? -p_q[WIDTH-1:0] : p_q[WIDTH-1:0];
    rem    = rneg_q ? -p_q[2*WIDTH-1:WIDTH] : p_q[2*WIDTH-1:WIDTH];
    cnt_d  = cnt_q;
    p_d    = p_q;
    m_d    = m_q;
    a_d    = a_q;
    div_d  = div_q;
    neg_d  = neg_q;
    rneg_d = rneg_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    if (accept) begin
      cnt_d  = '0;
      a_d    = a;
      div_d  = Func[1];
      neg_d  = sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
      rneg_d = sgn && a[WIDTH-1];
      m_d    = Func[1] ? abs_b : abs_a;
      p_d    = {{WIDTH{1'b0}}, Func[1] ? abs_a : abs_b};
    end
    if (state_q == MUL) begin
      p_d   = {sum, p_q[WIDTH-1:1]};
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == DIV) begin
      p_d   = (trial >= {1'b0, m_q}) ? {WIDTH'(trial - {1'b0, m_q}), p_q[WIDTH-2:0], 1'b1}
                                     : {p_q[2*WIDTH-2:0], 1'b0};
      cnt_d = cnt_q + 1'b1;
    end
    if (state_q == FIX) begin
      {hi_d, lo_d} = !div_q ? prod : (m_q == '0) ? {a_q, {WIDTH{1'b1}}} : {rem, quo};
    end
    busy_d = state_d == MUL || state_d == DIV || state_d == FIX;
    done_d = state_d == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      p_q    <= '0;
      m_q    <= '0;
      a_q    <= '0;
      div_q  <= 1'b0;
      neg_q  <= 1'b0;
      rneg_q <= 1'b0;
      hi_q   <= '0;
      lo_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      p_q    <= p_d;
      m_q    <= m_d;
      a_q    <= a_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
endmodule
